// File: rtl/lfsr_pkg.sv
// Shared constants and reference next-state function for the Galois LFSR generator.
package lfsr_pkg;

  localparam logic [2:0] TAPS_3 = 3'b010;
  localparam logic [5:0] TAPS_6 = 6'b110100;

  // Generic Galois step over up to 32 bits; bits at and above width are returned as zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q, input logic [31:0] taps,
                                            input int unsigned width);
    logic        m;
    logic [31:0] d;
    m    = q[5'(width - 1)];
    d    = '0;
    d[0] = m;
    for (int k = 1; k < 32; k++) begin
      if (k < int'(width)) d[k] = q[k-1] ^ (taps[k] & m);
    end
    return d;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Galois LFSR next-state: the MSB feeds bit 0 and is XORed into tapped bits.
module lfsr_step #(
  parameter int unsigned          WIDTH = 6,
  parameter logic [WIDTH-1:0]     TAPS  = 6'b110100
) (
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] d_o
);

  logic m;
  assign m = q_i[WIDTH-1];

  always_comb begin
    d_o    = '0;
    d_o[0] = m;
    for (int k = 1; k < int'(WIDTH); k++) begin
      d_o[k] = q_i[k-1] ^ (TAPS[k] & m);
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with step enable, seed loading, zero-seed lockup recovery
// and measurement of the sequence period between returns to the start value.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_6,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] step_d;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .q_i (q_q),
    .d_o (step_d)
  );

  always_comb begin
    q_d      = q_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      // A zero seed would lock the register at zero forever; substitute SEED.
      if (seed_in != '0) begin
        q_d     = seed_in;
        start_d = seed_in;
      end else begin
        q_d      = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end
      cnt_d = '0;
    end else if (en) begin
      q_d = step_d;
      if (step_d == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_q + WIDTH'(1);
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign q       = q_q;
  assign bit_out = q_q[WIDTH-1];
  assign wrap    = wrap_q;
  assign period  = period_q;
  assign lockup  = lockup_q;

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Galois LFSR pseudo-random generator. It generalises the fixed 6-bit all-ones-seeded generator to any width and tap set, and adds step enable, runtime seed loading, zero-state lockup protection and sequence-period measurement. It sits beside test-pattern and scrambler logic as the shared pseudo-random source.

## Interface
- WIDTH, 6, register width; legal range 3..32.
- TAPS, 6'b110100, Galois tap mask, WIDTH bits. Bit k=1 (k≥1) means the next d[k] = q[k-1] ^ q[WIDTH-1]; bit 0 is ignored.
- SEED, all ones, value used at reset and for lockup recovery. Must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance one step this cycle.
- load  in  1  load `seed_in` this cycle; has priority over `en`.
- seed_in  in  WIDTH  value to load.
- q  out  WIDTH  current state.
- bit_out  out  1  q[WIDTH-1], the serial output.
- wrap  out  1  one-cycle pulse when a step returns the state to the start value.
- period  out  WIDTH  step count of the last completed cycle; held until the next wrap.
- lockup  out  1  one-cycle pulse when a zero seed was replaced by SEED.

## Operation
- Next-state function, with m = q[WIDTH-1]:
  - d[0] = m.
  - For k ≥ 1: d[k] = q[k-1] ^ (TAPS[k] & m).
- Registers: `q`, `start` (reference value for wrap detection), `cnt` (steps since start), `period`, `wrap`, `lockup`.
- **Load** (load=1):
  - If seed_in ≠ 0: q ← seed_in, start ← seed_in.
  - If seed_in = 0: q ← SEED, start ← SEED, lockup ← 1.
  - In both cases cnt ← 0 and wrap ← 0. `period` keeps its value.
- **Step** (load=0, en=1):
  - q ← d.
  - If d == start: wrap ← 1, period ← cnt+1, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
- **Idle** (load=0, en=0): q, start and cnt hold.
- `wrap` and `lockup` are 0 in every cycle that did not set them.
- The all-zero state is unreachable: the seed check guarantees it, and the Galois update is invertible.
- `cnt` never exceeds 2^WIDTH−2, so WIDTH bits suffice and no saturation is needed.

## Timing
- Reset values: q = SEED, start = SEED, cnt = 0, period = 0, wrap = 0, lockup = 0. These apply immediately when rst rises, with no clock needed.
- Latency:
  - `q` updates one clock after a sampled load or en.
  - `bit_out` is combinational from q.
  - `wrap`, `period` and `lockup` are registered and become valid in the same cycle as the q that caused them.
- load and en both high: load wins and no step occurs.
- rst asserted mid-sequence: all registers return to reset values asynchronously. The first step after rst falls uses SEED as the start value.
- Back-to-back loads: each one reloads and clears cnt. A wrap is never reported for a partial sequence.

## Structure
- Package `lfsr_pkg` holds:
  - Default tap-mask constants: TAPS_3 = 3'b010, TAPS_6 = 6'b110100, etc.
  - Function `lfsr_next(q, taps)` returning the Galois next state.
- One combinational sub-module `lfsr_step` (WIDTH, TAPS) computes d.
- The top level holds all registers and the load/wrap control.

## Test plan
- Reset, default params, en=1:
  - q = 6'h3F during reset.
  - Then 6'h0B, 6'h16, 6'h2C, 6'h2D on successive clocks.
  - bit_out follows q[5].
- WIDTH=3, TAPS=3'b010, SEED=3'b111, en=1:
  - Sequence 111, 101, 001, 010, 100, 011, 110, 111.
  - wrap pulses with period = 7 on the return to 111, and again every 7 clocks.
- WIDTH=3, load seed_in = 3'b010, then en=1:
  - Sequence 100, 011, …
  - After 7 steps q = 010, wrap = 1, period = 7.
- load seed_in = 0:
  - Next q = SEED, lockup = 1 for exactly one cycle.
  - q never equals 0 afterwards.
- load=1 and en=1 in the same cycle with seed_in = 6'h15: next q = 6'h15 (no step). Then en=0 for 5 clocks: q stays 6'h15.
- rst pulse mid-sequence (q = 6'h2C):
  - q = 6'h3F, cnt = 0, period = 0 asynchronously.
  - Stepping resumes with 6'h0B after release.
